// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Every operation takes 32 CALC iterations, then FIX, then a DONE cycle.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             decoded M-extension instruction present (level)
//   funct3            M-extension operation select
//   SrcA, SrcB        rs1 / rs2 operands
//   busy              combinational stall request to the core
//   done              registered, high for the single DONE cycle
//   result            registered result, held until the next FIX
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned W      = 32;
   localparam int unsigned CW     = 6;
   localparam int unsigned LAST   = 31;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   cnt;
   logic [2:0]      op;
   logic            sign_a;
   logic            sign_b;
   logic [W-1:0]    mag_a;
   logic [W-1:0]    mag_b;
   // acc_hi/acc_lo: product {hi,lo} when multiplying; remainder/quotient when dividing
   logic [W:0]      acc_hi;
   logic [W-1:0]    acc_lo;

   // Operand decode at accept time
   logic            a_signed;
   logic            b_signed;
   logic            in_sign_a;
   logic            in_sign_b;
   logic [W-1:0]    in_mag_a;
   logic [W-1:0]    in_mag_b;

   always_comb begin
      a_signed  = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                  (funct3 == OP_DIV)  || (funct3 == OP_REM);
      b_signed  = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
      in_sign_a = a_signed & SrcA[W-1];
      in_sign_b = b_signed & SrcB[W-1];
      in_mag_a  = in_sign_a ? W'(~SrcA + W'(1)) : SrcA;
      in_mag_b  = in_sign_b ? W'(~SrcB + W'(1)) : SrcB;
   end

   // One shift-add multiply step and one restoring-divide step
   logic [W:0]      mul_sum;
   logic [W:0]      div_shift;
   logic [W:0]      div_diff;
   logic            div_ge;

   always_comb begin
      mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, mag_a} : (W+1)'(0));
      div_shift = {acc_hi[W-1:0], acc_lo[W-1]};
      div_ge    = (div_shift >= {1'b0, mag_b});
      div_diff  = div_shift - {1'b0, mag_b};
   end

   // Sign correction and special-case override applied in FIX
   logic [2*W-1:0]  product;
   logic [2*W-1:0]  prod_fix;
   logic [W-1:0]    quo_fix;
   logic [W-1:0]    rem_fix;
   logic [W-1:0]    a_orig;
   logic            div_zero;
   logic            div_ovf;
   logic [W-1:0]    fix_value;

   always_comb begin
      product   = {acc_hi[W-1:0], acc_lo};
      prod_fix  = (sign_a ^ sign_b) ? (2*W)'(~product + (2*W)'(1)) : product;
      quo_fix   = (sign_a ^ sign_b) ? W'(~acc_lo + W'(1)) : acc_lo;
      rem_fix   = sign_a ? W'(~acc_hi[W-1:0] + W'(1)) : acc_hi[W-1:0];
      a_orig    = sign_a ? W'(~mag_a + W'(1)) : mag_a;
      div_zero  = (mag_b == W'(0));
      // Only the signed ops can see -2^31 / -1 (magnitudes 2^31 and 1, both negative)
      div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && sign_a && sign_b &&
                  (mag_a == 32'h8000_0000) && (mag_b == W'(1));
      fix_value = '0;
      case (op)
         OP_MUL:                      fix_value = prod_fix[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_value = prod_fix[2*W-1:W];
         OP_DIV, OP_DIVU: begin
            if (div_zero)      fix_value = 32'hFFFF_FFFF;
            else if (div_ovf)  fix_value = 32'h8000_0000;
            else               fix_value = quo_fix;
         end
         OP_REM, OP_REMU: begin
            if (div_zero)      fix_value = a_orig;
            else if (div_ovf)  fix_value = '0;
            else               fix_value = rem_fix;
         end
         default:                     fix_value = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and stall request
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            busy = start;
            if (start) state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == CW'(LAST)) state_next = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand latch, iteration, result write
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         op     <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= '0;
                  op     <= funct3;
                  sign_a <= in_sign_a;
                  sign_b <= in_sign_b;
                  mag_a  <= in_mag_a;
                  mag_b  <= in_mag_b;
                  acc_hi <= '0;
                  // Multiplier bits shift out of acc_lo; dividend bits likewise
                  acc_lo <= funct3[2] ? in_mag_a : in_mag_b;
               end
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (op[2]) begin
                  acc_hi <= div_ge ? div_diff : div_shift;
                  acc_lo <= {acc_lo[W-2:0], div_ge};
               end else begin
                  acc_hi <= {1'b0, mul_sum[W:1]};
                  acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
               end
            end
            FIX:     result <= fix_value;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op with start held through DONE; operands scrambled during CALC.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int done_at,
                         output int done_cnt, output int busy_cnt);
      done_at  = -1;
      done_cnt = 0;
      busy_cnt = 0;
      res      = 32'h0;
      for (int k = 0; k < 37; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b1; funct3 = f3; SrcA = a; SrcB = b;
         end else if (k == 1) begin
            SrcA = ~a; SrcB = b ^ 32'h00FF_1234; funct3 = f3 ^ 3'b001;
         end else if (k == 35) begin
            start = 1'b0;
         end
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               res     = result;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; funct3 = 3'b000; SrcA = '0; SrcB = '0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++;
      if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=00000000", result); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Apply a table of ops and check result, latency, pulse count, stall length
   task automatic check_table(input string tag, input int n,
                              input logic [2:0] f3s [8], input logic [31:0] as [8],
                              input logic [31:0] bs [8], input logic [31:0] exps [8]);
      logic [31:0] res;
      int d_at, d_cnt, b_cnt;
      for (int i = 0; i < n; i++) begin
         run_op(f3s[i], as[i], bs[i], res, d_at, d_cnt, b_cnt);
         n_checks++;
         if (res !== exps[i]) begin
            n_fail++; $display("FAIL %s[%0d]_result got=%h exp=%h", tag, i, res, exps[i]);
         end
         n_checks++;
         if (d_at != 34) begin
            n_fail++; $display("FAIL %s[%0d]_done_cycle got=%0d exp=34", tag, i, d_at);
         end
         n_checks++;
         if (d_cnt != 1) begin
            n_fail++; $display("FAIL %s[%0d]_done_pulses got=%0d exp=1", tag, i, d_cnt);
         end
         n_checks++;
         if (b_cnt != 34) begin
            n_fail++; $display("FAIL %s[%0d]_busy_cycles got=%0d exp=34", tag, i, b_cnt);
         end
      end
   endtask

   task automatic test_multiply();
      logic [2:0]  f3s  [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 0, 0, 0};
      logic [31:0] as   [8] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h1234_5678, 0, 0, 0};
      logic [31:0] bs   [8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h10, 0, 0, 0};
      logic [31:0] exps [8] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'h2345_6780, 0, 0, 0};
      check_table("mul", 5, f3s, as, bs, exps);
   endtask

   task automatic test_divide();
      logic [2:0]  f3s  [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 0, 0, 0, 0};
      logic [31:0] as   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 0, 0, 0, 0};
      logic [31:0] bs   [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 0, 0, 0, 0};
      logic [31:0] exps [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 0, 0, 0, 0};
      check_table("div", 4, f3s, as, bs, exps);
   endtask

   task automatic test_special();
      logic [2:0]  f3s  [8] = '{3'b101, 3'b110, 3'b100, 3'b111, 3'b100, 3'b110, 3'b110, 0};
      logic [31:0] as   [8] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0001,
                                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 0};
      logic [31:0] bs   [8] = '{32'd0, 32'd0, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0};
      logic [31:0] exps [8] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0001,
                                32'h8000_0000, 32'd0, 32'hFFFF_FFFB, 0};
      check_table("special", 7, f3s, as, bs, exps);
   endtask

   task automatic test_mid_reset();
      logic [2:0]  f3s  [8] = '{3'b000, 0, 0, 0, 0, 0, 0, 0};
      logic [31:0] as   [8] = '{32'd3, 0, 0, 0, 0, 0, 0, 0};
      logic [31:0] bs   [8] = '{32'd4, 0, 0, 0, 0, 0, 0, 0};
      logic [31:0] exps [8] = '{32'd12, 0, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b1; funct3 = 3'b100; SrcA = 32'd100; SrcB = 32'd7;
         end else if (k == 10) begin
            rst = 1'b1; start = 1'b0;
         end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
      n_checks++;
      if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result got=%h exp=00000000", result); end
      rst = 1'b0;
      check_table("after_rst", 1, f3s, as, bs, exps);
   endtask

   // start held continuously across two instructions
   task automatic test_back_to_back();
      int d_cnt = 0;
      int d1 = -1;
      int d2 = -1;
      logic [31:0] r1 = '0;
      logic [31:0] r2 = '0;
      logic b34 = 1'b1;
      logic b35 = 1'b0;
      for (int k = 0; k < 73; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b1; funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD;
         end else if (k == 35) begin
            funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
         end else if (k == 40) begin
            SrcA = 32'hDEAD_BEEF;
         end else if (k == 70) begin
            start = 1'b0;
         end
         #1;
         if (k == 34) b34 = busy;
         if (k == 35) b35 = busy;
         if (done) begin
            d_cnt++;
            if (d1 < 0) begin d1 = k; r1 = result; end
            else if (d2 < 0) begin d2 = k; r2 = result; end
         end
      end
      n_checks++;
      if (d_cnt != 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", d_cnt); end
      n_checks++;
      if (d1 != 34) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=34", d1); end
      n_checks++;
      if (d2 != 69) begin n_fail++; $display("FAIL b2b_second_done got=%0d exp=69", d2); end
      n_checks++;
      if (r1 !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL b2b_first_result got=%h exp=ffffffeb", r1); end
      n_checks++;
      if (r2 !== 32'd14) begin n_fail++; $display("FAIL b2b_second_result got=%h exp=0000000e", r2); end
      n_checks++;
      if (b34 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_done got=%b exp=0", b34); end
      n_checks++;
      if (b35 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_restart got=%b exp=1", b35); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; funct3 = '0; SrcA = '0; SrcB = '0;
      test_reset();
      test_multiply();
      test_divide();
      test_special();
      test_mid_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, placed beside the ALU in the execute stage. It takes the same SrcA/SrcB operands as the ALU and feeds the writeback mux. The single-cycle core holds its PC and register write while `busy` is high. The block has a fixed-latency state machine, with one accepted operation per M-extension instruction.

## Interface
- Parameters: none; the width is fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  decoded M-extension instruction is present (level; held by the core while stalled)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  32  rs1 operand (multiplicand / dividend)
- SrcB  in  32  rs2 operand (multiplier / divisor)
- busy  out  1  stall request to the core: combinational, `(state==IDLE && start) || state==CALC || state==FIX`
- done  out  1  registered; high for exactly the DONE cycle
- result  out  32  registered; valid while `done`; held until the next FIX→DONE transition

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: 32 iterations.
  - FIX: sign correction and special-case override; writes `result`.
  - DONE: one cycle, then back to IDLE.
- IDLE → CALC on `start`:
  - Latch funct3, the operand signs, and the operand magnitudes.
  - Clear the 6-bit iteration counter.
- Magnitude and sign rules:
  - Signed operands are converted to magnitude: SrcA is signed for MULH, MULHSU, DIV and REM; SrcB is signed for MULH, DIV and REM.
  - Product sign is signA XOR signB.
  - Quotient sign is signA XOR signB.
  - Remainder sign is signA.
- Multiply:
  - Shift-add over a 64-bit accumulator, one multiplier bit per CALC cycle.
  - FIX negates the product if required.
  - MUL returns bits [31:0]; the other multiply ops return bits [63:32].
- Divide:
  - Restoring division, one quotient bit per CALC cycle, using a 33-bit partial remainder.
  - FIX negates the quotient and remainder per the sign rules.
- Special cases are applied in FIX and override the computed value; latency is unchanged.
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcA unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; the matching REM returns 0.
- CALC → FIX when the counter reaches 31 (32 iterations). FIX → DONE unconditionally. DONE → IDLE unconditionally.
- `start`, funct3, SrcA and SrcB are ignored in CALC, FIX and DONE. Operand changes during an operation have no effect.
- DONE ignores `start` so the still-present instruction does not retrigger. The next instruction is accepted in IDLE.

## Timing
- Reset (any state, including mid-operation): state IDLE, counter 0, `result` 0x00000000, `done` 0, registered part of `busy` 0. Effective at the next edge.
- Start accepted at edge E0:
  - CALC runs over E1..E32.
  - FIX writes `result` at E33.
  - `done`=1 and `busy`=0 in the cycle after E33.
  - IDLE is reached after E34.
- Latency from start edge to the `done` cycle is 33 edges. Throughput is one operation per 35 cycles.
- `busy` is high from the cycle `start` is first seen in IDLE through the FIX cycle: 34 consecutive cycles. The core writes back and advances PC in the DONE cycle.
- `result` is stable from DONE until the next FIX. A reset clears it.

## Test plan
- MUL, SrcA=7, SrcB=0xFFFFFFFD → result 0xFFFFFFEB; `done` high in exactly one cycle, 34 cycles after `start` is first sampled; `busy` high for 34 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. All cases keep the 34-cycle latency.
- Assert `rst` in the 10th CALC cycle → next cycle `busy`=0, `done`=0, `result`=0. A new MUL 3×4 started afterwards → 12 with normal latency.
- Hold `start`=1 through DONE, then change the operands → exactly one `done` pulse per instruction. The second operation starts only from IDLE, and SrcA changes during CALC do not alter `result`.
